// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   CMD_W       - width of one command word handed to the UART.
//   FRAME_BITS  - bits per UART character frame (start + 8 data + parity + stop).
//   cmd_t       - command word type.
//   FIFO_DEPTH  - default number of entries in the command buffer.
package uart_pkg;

    localparam int CMD_W      = 16;
    localparam int FRAME_BITS = 11;
    localparam int FIFO_DEPTH = 8;

    typedef logic [CMD_W-1:0] cmd_t;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Command buffer feeding the UART transmitter.
// First-word-fall-through queue: the head entry is always presented on
// cmd_in/cmd_vld and retired on the cmd_vld & cmd_rdy handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   wr_en        host write strobe
//   wr_data      host command word
//   flush        synchronous clear of contents, pointers and overflow
//   full         level == DEPTH (registered)
//   almost_full  level >= AFULL_TH (registered)
//   level        number of stored entries, 0..DEPTH
//   overflow     sticky: a write arrived while full and was dropped
//   cmd_in       head entry, 0 when the queue is empty
//   cmd_vld      head entry valid
//   cmd_rdy      UART ready to accept a command
module uart_cmd_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = CMD_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int AFULL_TH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic              full,
    output logic              almost_full,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic [DATA_W-1:0] cmd_in,
    output logic              cmd_vld,
    input  logic              cmd_rdy
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_full;
    logic              r_almost_full;
    logic              r_overflow;
    logic              r_cmd_vld;

    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [AW:0]       w_level_next;

    // full is registered state, so a pop in the same cycle does not make
    // room for a write; flush discards both sides of the handshake.
    assign w_push = wr_en & ~r_full & ~flush;
    assign w_pop  = r_cmd_vld & cmd_rdy & ~flush;
    assign w_drop = wr_en & r_full & ~flush;

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + (AW+1)'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_cmd_vld     <= 1'b0;
        end else if (flush) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_cmd_vld     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Status flags are derived from the next level so they change
            // on the same edge as the counter.
            r_level       <= w_level_next;
            r_full        <= (w_level_next == (AW+1)'(DEPTH));
            r_almost_full <= (w_level_next >= (AW+1)'(AFULL_TH));
            r_cmd_vld     <= (w_level_next != '0);
        end
    end

    // Storage has no reset; each entry loads only when it is the write target.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == AW'(gi))) begin
                r_mem[gi] <= wr_data;
            end
        end
    end

    // Masking with valid keeps cmd_in at 0 after reset even though the
    // array itself is uninitialised.
    assign cmd_in      = r_cmd_vld ? r_mem[r_rd_ptr] : '0;
    assign cmd_vld     = r_cmd_vld;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign level       = r_level;
    assign overflow    = r_overflow;

endmodule
